// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank on the shared 64-bit bus: OUT/DIR/IN registers, atomic
// set/clear, synchronised inputs and edge capture into a W1C pending register.
module gpio_bank #(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_0000_F000,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  inout  wire  [63:0]      data,
  input  logic [63:0]      address,
  input  logic             read,
  input  logic             write,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam int unsigned BUS_W = 64;
  localparam int unsigned IDX_W = 3;

  localparam logic [IDX_W-1:0] IDX_OUT  = 3'd0;
  localparam logic [IDX_W-1:0] IDX_DIR  = 3'd1;
  localparam logic [IDX_W-1:0] IDX_IN   = 3'd2;
  localparam logic [IDX_W-1:0] IDX_REN  = 3'd3;
  localparam logic [IDX_W-1:0] IDX_FEN  = 3'd4;
  localparam logic [IDX_W-1:0] IDX_PEND = 3'd5;
  localparam logic [IDX_W-1:0] IDX_SET  = 3'd6;
  localparam logic [IDX_W-1:0] IDX_CLR  = 3'd7;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  logic             sel;
  logic             wr_en;
  logic             rd_en;
  logic [IDX_W-1:0] reg_idx;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] rd_val;
  logic [BUS_W-1:0] rd_data;
  logic             unused_bits;

  assign sel     = (address[63:6] == BASE_ADDR[63:6]);
  assign reg_idx = address[5:3];
  assign wr_en   = sel && write;
  assign rd_en   = sel && read && !write && !reset;
  assign wr_data = data[WIDTH-1:0];
  assign in_sync = sync_q[SYNC_STAGES-1];

  assign rise = in_sync & ~prev_q & rise_en_q;
  assign fall = ~in_sync & prev_q & fall_en_q;

  assign unused_bits = ^{address[2:0], data};

  // Synchroniser chain; prev tracks IN one cycle late for edge detection.
  always_comb begin
    sync_d[0] = gpio_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = in_sync;
  end

  // Register writes; a new edge on a bit wins over a same-cycle W1C of that bit.
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr_mask  = '0;
    if (wr_en) begin
      case (reg_idx)
        IDX_OUT:  out_d     = wr_data;
        IDX_DIR:  dir_d     = wr_data;
        IDX_REN:  rise_en_d = wr_data;
        IDX_FEN:  fall_en_d = wr_data;
        IDX_PEND: clr_mask  = wr_data;
        IDX_SET:  out_d     = out_q | wr_data;
        IDX_CLR:  out_d     = out_q & ~wr_data;
        default:  ;
      endcase
    end
    pend_d = (pend_q & ~clr_mask) | rise | fall;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q    <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
    end else begin
      sync_q    <= sync_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      prev_q    <= prev_d;
    end
  end

  // Combinational read mux; SET and CLR read back as zero.
  always_comb begin
    rd_val = '0;
    case (reg_idx)
      IDX_OUT:  rd_val = out_q;
      IDX_DIR:  rd_val = dir_q;
      IDX_IN:   rd_val = in_sync;
      IDX_REN:  rd_val = rise_en_q;
      IDX_FEN:  rd_val = fall_en_q;
      IDX_PEND: rd_val = pend_q;
      default:  rd_val = '0;
    endcase
    rd_data = BUS_W'(rd_val);
  end

  assign data     = rd_en ? rd_data : {BUS_W{1'bz}};
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |pend_q;

endmodule
